fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per req/ack handshake, holds it for decode.
// Optional: define FETCH_ALIGN_CHECK_EN to word-align misaligned redirects and flag them on align_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rn,
  output logic [3:0]  Rd,
  output logic [11:0] Src2,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  output logic        align_err
);

  typedef enum logic [1:0] {
    StRst,
    StFetch,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        align_err_q, align_err_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    align_err_d = align_err_q;
    case (state_q)
      StRst: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        // Redirect inputs only matter on the consume edge.
        if (valid_q && !stall) begin
          valid_d = 1'b0;
          state_d = StFetch;
          if (PCSrc) begin
            pc_d = branch_target;
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00) begin
              pc_d        = {branch_target[31:2], 2'b00};
              align_err_d = 1'b1;
            end
`endif
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRst;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      pc_out_q    <= RESET_PC;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign Instr       = instr_q;
  assign Cond        = instr_q[31:28];
  assign Op          = instr_q[27:26];
  assign Funct       = instr_q[25:20];
  assign Rn          = instr_q[19:16];
  assign Rd          = instr_q[15:12];
  assign Src2        = instr_q[11:0];
  assign pc_out      = pc_out_q;
  assign pc_plus8    = pc_out_q + 32'd8;

`ifdef FETCH_ALIGN_CHECK_EN
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (one fetch, optional waits/stalls, one consume per instruction).
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [11:0] Src2;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic        align_err;

  int total;
  int bad;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .Instr        (Instr),
    .Cond         (Cond),
    .Op           (Op),
    .Funct        (Funct),
    .Rn           (Rn),
    .Rd           (Rd),
    .Src2         (Src2),
    .pc_out       (pc_out),
    .pc_plus8     (pc_plus8),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, then release; leaves the DUT in its first fetch cycle.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; PCSrc = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Same-cycle ack of one word, leaving the DUT holding it with stall asserted.
  task automatic do_fetch(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word; stall = 1'b1;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b1; PCSrc = 1'b0;
    branch_target = 32'h0;
    step();
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (Instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instr); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
    total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align got=%b exp=0", align_err); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    rst = 1'b0; stall = 1'b0;
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    imem_rdata = 32'hE082_1003; stall = 1'b0; PCSrc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        bad++; $display("FAIL seq_fetch%0d req=%b addr=%h exp_addr=%h", i, imem_req, imem_addr, exp_pc);
      end
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== exp_pc) begin
        bad++; $display("FAIL seq_hold%0d valid=%b req=%b pc_out=%h exp=%h", i, instr_valid, imem_req,
                        pc_out, exp_pc);
      end
      total++;
      if (Cond !== 4'hE || Op !== 2'd0 || Funct !== 6'b001000 || Rn !== 4'd2 || Rd !== 4'd1 ||
          Src2 !== 12'h003 || Instr !== 32'hE082_1003) begin
        bad++; $display("FAIL seq_fields%0d instr=%h cond=%h op=%h funct=%b rn=%h rd=%h src2=%h",
                        i, Instr, Cond, Op, Funct, Rn, Rd, Src2);
      end
      total++;
      if (pc_plus8 !== exp_pc + 32'd8) begin
        bad++; $display("FAIL seq_pc_plus8%0d got=%h exp=%h", i, pc_plus8, exp_pc + 32'd8);
      end
      step();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_delayed_ack();
    logic [31:0] addr0;
    logic [31:0] word;
    addr0 = 32'hC;
    word = $urandom;
    imem_rdata = word;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== addr0 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL delay_wait%0d req=%b addr=%h valid=%b exp_addr=%h", i, imem_req,
                        imem_addr, instr_valid, addr0);
      end
      step();
    end
    imem_ack = 1'b0; stall = 1'b1;
    total++;
    if (instr_valid !== 1'b1 || Instr !== word || pc_out !== addr0) begin
      bad++; $display("FAIL delay_capture valid=%b instr=%h exp=%h pc_out=%h", instr_valid, Instr,
                      word, pc_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    held_instr = Instr;
    held_pc    = 32'hC;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCSrc = (i == 2); branch_target = 32'h0000_0400;
      imem_ack = 1'b1; imem_rdata = ~held_instr;
      step();
      total++;
      if (Instr !== held_instr || pc_out !== held_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        bad++; $display("FAIL stall%0d instr=%h pc_out=%h req=%b valid=%b", i, Instr, pc_out,
                        imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0; PCSrc = 1'b0; stall = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== held_pc + 32'd4) begin
      bad++; $display("FAIL stall_resume req=%b addr=%h exp=%h", imem_req, imem_addr, held_pc + 32'd4);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_fetch($urandom);
      if (i < 2) begin
        stall = 1'b0;
        step();
      end
    end
    // Held at pc 8; pulse PCSrc while stalled.
    PCSrc = 1'b1; branch_target = 32'h0000_0200;
    step();
    PCSrc = 1'b0;
    step();
    total++;
    if (pc_out !== 32'h8 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL branch_stalled pc_out=%h valid=%b exp pc_out=8", pc_out, instr_valid);
    end
    stall = 1'b0; PCSrc = 1'b1; branch_target = 32'h0000_0100;
    step();
    PCSrc = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL branch_redirect req=%b addr=%h exp=100", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL midrst req=%b valid=%b exp 0/0", imem_req, instr_valid);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || Instr !== 32'h0) begin
      bad++; $display("FAIL midrst_late_ack req=%b addr=%h valid=%b instr=%h", imem_req, imem_addr,
                      instr_valid, Instr);
    end
  endtask

  task automatic test_align();
    logic [31:0] exp_addr;
    logic        exp_err;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_addr = 32'h100; exp_err = 1'b1;
`else
    exp_addr = 32'h102; exp_err = 1'b0;
`endif
    do_reset();
    do_fetch($urandom);
    stall = 1'b0; PCSrc = 1'b1; branch_target = 32'h102;
    step();
    PCSrc = 1'b0;
    total++;
    if (imem_addr !== exp_addr || align_err !== exp_err) begin
      bad++; $display("FAIL align_redirect addr=%h exp=%h err=%b exp=%b", imem_addr, exp_addr,
                      align_err, exp_err);
    end
    do_fetch($urandom);
    stall = 1'b0;
    step();
    total++;
    if (align_err !== exp_err || imem_addr !== exp_addr + 32'd4) begin
      bad++; $display("FAIL align_sticky err=%b exp=%b addr=%h", align_err, exp_err, imem_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (align_err !== 1'b0) begin bad++; $display("FAIL align_clear got=%b exp=0", align_err); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_align;
    logic [31:0] word;
    logic [31:0] tgt;
    logic        take;
    int          waits;
    int          stalls;
    do_reset();
    m_pc = 32'h0; m_align = 1'b0;
    for (int n = 0; n < 200; n++) begin
      waits = $urandom_range(0, 3);
      word  = $urandom;
      for (int w = 0; w <= waits; w++) begin
        imem_ack = (w == waits); imem_rdata = (w == waits) ? word : $urandom;
        PCSrc = $urandom_range(0, 1); branch_target = $urandom; stall = $urandom_range(0, 1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_fetch n=%0d req=%b addr=%h exp=%h valid=%b", n, imem_req,
                          imem_addr, m_pc, instr_valid);
        end
        step();
      end
      stalls = $urandom_range(0, 3);
      for (int s = 0; s <= stalls; s++) begin
        imem_ack = $urandom_range(0, 1); imem_rdata = $urandom;
        total++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || Instr !== word || pc_out !== m_pc ||
            pc_plus8 !== m_pc + 32'd8 || align_err !== m_align) begin
          bad++; $display("FAIL rnd_hold n=%0d valid=%b instr=%h exp=%h pc_out=%h exp=%h err=%b",
                          n, instr_valid, Instr, word, pc_out, m_pc, align_err);
        end
        total++;
        if (Cond !== 4'(word >> 28) || Op !== 2'(word >> 26) || Funct !== 6'(word >> 20) ||
            Rn !== 4'(word >> 16) || Rd !== 4'(word >> 12) || Src2 !== 12'(word)) begin
          bad++; $display("FAIL rnd_fields n=%0d instr=%h cond=%h op=%h funct=%h rn=%h rd=%h src2=%h",
                          n, Instr, Cond, Op, Funct, Rn, Rd, Src2);
        end
        take = $urandom_range(0, 1);
        tgt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
        PCSrc = take; branch_target = tgt;
        stall = (s != stalls);
        step();
        if (s == stalls) begin
          if (!take) begin
            m_pc = m_pc + 32'd4;
          end else begin
            m_pc = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt % 4 != 0) begin
              m_pc = tgt - (tgt % 4);
              m_align = 1'b1;
            end
`endif
          end
        end
      end
    end
    imem_ack = 1'b0; PCSrc = 1'b0; stall = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_stall();
    test_branch();
    test_reset_mid_fetch();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
